// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with bounded locking in front of dmem and the UART MMIO window.
// Optional per-port grant and contention counters are compiled in with `define DMEM_ARB_PERF_EN.
module dmem_arbiter #(
   parameter int          MAX_LOCK       = 8,
   parameter logic [31:0] UART_TX_ADDR   = 32'hFFFF_FFFC,
   parameter logic [31:0] UART_STAT_ADDR = 32'hFFFF_FFF8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req,
   input  logic [1:0]  lock,
   input  logic [1:0]  wen,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   input  logic [2:0]  size0,
   input  logic [2:0]  size1,
   output logic [1:0]  gnt,
   output logic [1:0]  rvalid,
   output logic [31:0] rdata,
   output logic        mRen,
   output logic        mWen,
   output logic [31:0] mAddr,
   output logic [31:0] mWdata,
   output logic [2:0]  mSize,
   input  logic [31:0] mRdata,
   output logic        uartWen,
   output logic [7:0]  uartData,
   input  logic        uartFifoFull
);

   localparam int LCW = $clog2(MAX_LOCK + 1);

`ifdef DMEM_ARB_PERF_EN
   localparam logic [31:0] PERF_CORE_ADDR   = 32'hFFFF_FFF0;
   localparam logic [31:0] PERF_LOADER_ADDR = 32'hFFFF_FFF4;
   localparam logic [31:0] PERF_CONT_ADDR   = 32'hFFFF_FFEC;
`endif

   logic           rr_ptr;
   logic           owner_vld;
   logic           owner_idx;
   logic           owner_lock;
   logic [LCW-1:0] lock_cnt;

   logic           rd_pend;
   logic           rd_port;
   logic           rd_from_dmem;
   logic [31:0]    rd_mmio;

   logic [1:0]     tx_wr;
   logic [1:0]     elig;
   logic           hold;
   logic           any_gnt;
   logic           win;
   logic           sel;
   logic [31:0]    sel_addr;
   logic [31:0]    sel_wdata;
   logic           sel_wen;
   logic           hit_tx;
   logic           hit_stat;
   logic           hit_perf;
   logic           to_dmem;
   logic           rd_issue;
   logic [31:0]    mmio_val;

`ifdef DMEM_ARB_PERF_EN
   logic [31:0]    cnt_core;
   logic [31:0]    cnt_loader;
   logic [31:0]    cnt_cont;
   logic           clr_core;
   logic           clr_loader;
   logic           clr_cont;
`endif

   // A UART write stalled by a full FIFO simply drops out of arbitration; reset masks everything.
   always_comb begin
      tx_wr[0] = wen[0] && (addr0 == UART_TX_ADDR);
      tx_wr[1] = wen[1] && (addr1 == UART_TX_ADDR);
      elig     = req & ~(tx_wr & {2{uartFifoFull}}) & {2{rst}};
   end

   always_comb begin
      any_gnt = 1'b0;
      win     = rr_ptr;
      hold    = owner_vld && owner_lock && lock[owner_idx] && elig[owner_idx]
                && (lock_cnt < LCW'(MAX_LOCK));
      if (hold) begin
         any_gnt = 1'b1;
         win     = owner_idx;
      end else if (elig[rr_ptr]) begin
         any_gnt = 1'b1;
         win     = rr_ptr;
      end else if (elig[~rr_ptr]) begin
         any_gnt = 1'b1;
         win     = ~rr_ptr;
      end
      gnt = 2'b00;
      if (any_gnt) begin
         gnt = win ? 2'b10 : 2'b01;
      end
   end

   // With no grant the mux keeps pointing at the last winner so the bus does not toggle needlessly.
   always_comb begin
      sel       = any_gnt ? win : owner_idx;
      sel_addr  = sel ? addr1 : addr0;
      sel_wdata = sel ? wdata1 : wdata0;
      sel_wen   = wen[sel];
      mAddr     = sel_addr;
      mWdata    = sel_wdata;
      mSize     = sel ? size1 : size0;
      uartData  = sel_wdata[7:0];
   end

   always_comb begin
      hit_tx   = (sel_addr == UART_TX_ADDR);
      hit_stat = (sel_addr == UART_STAT_ADDR);
`ifdef DMEM_ARB_PERF_EN
      hit_perf = (sel_addr == PERF_CORE_ADDR) || (sel_addr == PERF_LOADER_ADDR)
                 || (sel_addr == PERF_CONT_ADDR);
`else
      hit_perf = 1'b0;
`endif
      to_dmem  = !(hit_tx || hit_stat || hit_perf);
      mRen     = any_gnt && !sel_wen && to_dmem;
      mWen     = any_gnt &&  sel_wen && to_dmem;
      uartWen  = any_gnt &&  sel_wen && hit_tx;
      rd_issue = any_gnt && !sel_wen;
   end

   // MMIO read data is captured in the grant cycle; UART TX reads and status writes return nothing useful.
   always_comb begin
      mmio_val = 32'h0;
      if (hit_stat) begin
         mmio_val = {31'b0, uartFifoFull};
      end
`ifdef DMEM_ARB_PERF_EN
      if (sel_addr == PERF_CORE_ADDR) begin
         mmio_val = cnt_core;
      end else if (sel_addr == PERF_LOADER_ADDR) begin
         mmio_val = cnt_loader;
      end else if (sel_addr == PERF_CONT_ADDR) begin
         mmio_val = cnt_cont;
      end
`endif
   end

   // Lock run length counts consecutive locked grants to the same port; hitting MAX_LOCK yields one arbitration.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr     <= 1'b0;
         owner_vld  <= 1'b0;
         owner_idx  <= 1'b0;
         owner_lock <= 1'b0;
         lock_cnt   <= '0;
      end else if (any_gnt) begin
         rr_ptr     <= ~win;
         owner_vld  <= 1'b1;
         owner_idx  <= win;
         owner_lock <= lock[win];
         if (owner_vld && (win == owner_idx) && owner_lock && lock[win]
             && (lock_cnt < LCW'(MAX_LOCK))) begin
            lock_cnt <= lock_cnt + 1'b1;
         end else begin
            lock_cnt <= LCW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_pend      <= 1'b0;
         rd_port      <= 1'b0;
         rd_from_dmem <= 1'b0;
         rd_mmio      <= 32'h0;
      end else begin
         rd_pend <= rd_issue;
         if (rd_issue) begin
            rd_port      <= win;
            rd_from_dmem <= to_dmem;
            rd_mmio      <= mmio_val;
         end
      end
   end

   always_comb begin
      rvalid = 2'b00;
      rdata  = 32'h0;
      if (rd_pend) begin
         rvalid = rd_port ? 2'b10 : 2'b01;
         rdata  = rd_from_dmem ? mRdata : rd_mmio;
      end
   end

`ifdef DMEM_ARB_PERF_EN
   always_comb begin
      clr_core   = any_gnt && sel_wen && (sel_addr == PERF_CORE_ADDR);
      clr_loader = any_gnt && sel_wen && (sel_addr == PERF_LOADER_ADDR);
      clr_cont   = any_gnt && sel_wen && (sel_addr == PERF_CONT_ADDR);
   end

   // A clearing write wins over an increment in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_core   <= 32'h0;
         cnt_loader <= 32'h0;
         cnt_cont   <= 32'h0;
      end else begin
         if (clr_core) begin
            cnt_core <= 32'h0;
         end else if (gnt[0]) begin
            cnt_core <= cnt_core + 32'd1;
         end
         if (clr_loader) begin
            cnt_loader <= 32'h0;
         end else if (gnt[1]) begin
            cnt_loader <= cnt_loader + 32'd1;
         end
         if (clr_cont) begin
            cnt_cont <= 32'h0;
         end else if ((req == 2'b11) && any_gnt) begin
            cnt_cont <= cnt_cont + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected grants and read returns into
// queues, and a negedge monitor pops and compares whenever the DUT shows a grant or rvalid.
module tb_dmem_arbiter;

   localparam logic [31:0] TX   = 32'hFFFF_FFFC;
   localparam logic [31:0] STAT = 32'hFFFF_FFF8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  req = 2'b00;
   logic [1:0]  lock = 2'b00;
   logic [1:0]  wen = 2'b00;
   logic [31:0] addr0 = 32'h0;
   logic [31:0] addr1 = 32'h0;
   logic [31:0] wdata0 = 32'h0;
   logic [31:0] wdata1 = 32'h0;
   logic [2:0]  size0 = 3'd2;
   logic [2:0]  size1 = 3'd2;
   logic        uart_fifo_full = 1'b0;
   logic [31:0] m_rdata = 32'h0;

   logic [1:0]  gnt;
   logic [1:0]  rvalid;
   logic [31:0] rdata;
   logic        m_ren;
   logic        m_wen;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [2:0]  m_size;
   logic        uart_wen;
   logic [7:0]  uart_data;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   typedef struct {
      int          cyc;
      logic [1:0]  g;
      logic [2:0]  en;
      logic [31:0] a;
      logic [7:0]  ud;
   } gexp_t;

   typedef struct {
      int          cyc;
      logic [1:0]  port;
      logic [31:0] d;
   } rexp_t;

   gexp_t gq[$];
   rexp_t rq[$];

   dmem_arbiter dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .wen(wen),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .size0(size0), .size1(size1), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .mRen(m_ren), .mWen(m_wen), .mAddr(m_addr), .mWdata(m_wdata), .mSize(m_size),
      .mRdata(m_rdata), .uartWen(uart_wen), .uartData(uart_data),
      .uartFifoFull(uart_fifo_full)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory contents are a fixed pattern of the address, so any read has a known answer.
   function automatic logic [31:0] pat(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return {a[15:0], ~a[15:0]};
   endfunction

   always @(posedge clk) if (m_ren) m_rdata <= pat(m_addr);

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s @cyc %0d: got 0x%08h, want 0x%08h", name, cyc, act, exp);
      end
   endtask

   // Monitor: compares grants and read returns against the queued expectations for this cycle.
   always @(negedge clk) begin
      gexp_t ge;
      rexp_t re;
      while (gq.size() > 0 && gq[0].cyc < cyc) begin
         check_output("gnt_missing_cycle", cyc, gq[0].cyc);
         void'(gq.pop_front());
      end
      if (gnt != 2'b00) begin
         if (gq.size() == 0 || gq[0].cyc != cyc) begin
            check_output("gnt_unexpected", {30'b0, gnt}, 32'h0);
         end else begin
            ge = gq.pop_front();
            check_output("gnt", {30'b0, gnt}, {30'b0, ge.g});
            check_output("ren_wen_uartwen", {29'b0, m_ren, m_wen, uart_wen}, {29'b0, ge.en});
            if (ge.en[2] || ge.en[1]) check_output("maddr", m_addr, ge.a);
            if (ge.en[0]) check_output("uart_data", {24'b0, uart_data}, {24'b0, ge.ud});
         end
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
         check_output("rvalid_missing_cycle", cyc, rq[0].cyc);
         void'(rq.pop_front());
      end
      if (rvalid != 2'b00) begin
         if (rq.size() == 0 || rq[0].cyc != cyc) begin
            check_output("rvalid_unexpected", {30'b0, rvalid}, 32'h0);
         end else begin
            re = rq.pop_front();
            check_output("rvalid", {30'b0, rvalid}, {30'b0, re.port});
            check_output("rdata", rdata, re.d);
         end
      end
   end

   // Drives one cycle of inputs; eg is the hand-computed grant expected in that cycle.
   task automatic apply_stimulus(input logic [1:0] r, input logic [1:0] lk, input logic [1:0] w,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input logic full, input logic [1:0] eg);
      gexp_t       ge;
      rexp_t       re;
      logic        p;
      logic [31:0] a;
      logic [31:0] d;
      logic        tx;
      logic        st;
      @(posedge clk);
      #1;
      req = r; lock = lk; wen = w;
      addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
      uart_fifo_full = full;
      if (eg != 2'b00) begin
         p  = eg[1];
         a  = p ? a1 : a0;
         d  = p ? d1 : d0;
         tx = (a == TX);
         st = (a == STAT);
         ge.cyc = cyc;
         ge.g   = eg;
         ge.en  = {~tx & ~st & ~w[p], ~tx & ~st & w[p], tx & w[p]};
         ge.a   = a;
         ge.ud  = d[7:0];
         gq.push_back(ge);
         if (!w[p]) begin
            re.cyc  = cyc + 1;
            re.port = eg;
            re.d    = tx ? 32'h0 : (st ? {31'b0, full} : pat(a));
            rq.push_back(re);
         end
      end
   endtask

   task automatic check_quiet(input string tag);
      check_output({tag, "_gnt"}, {30'b0, gnt}, 32'h0);
      check_output({tag, "_rvalid"}, {30'b0, rvalid}, 32'h0);
      check_output({tag, "_enables"}, {29'b0, m_ren, m_wen, uart_wen}, 32'h0);
      check_output({tag, "_rdata"}, rdata, 32'h0);
   endtask

   initial begin
      int k;
      logic core_win;
      $display("[TB] start");
      req = 2'b11;
      repeat (2) @(posedge clk);
      #1;
      check_quiet("reset");
      @(posedge clk);
      #1;
      req = 2'b00;
      rst = 1'b1;

      // single core read, then plain alternation
      apply_stimulus(2'b01, 2'b00, 2'b00, 32'h100, 32'h0,   0, 0, 1'b0, 2'b01);
      apply_stimulus(2'b11, 2'b00, 2'b00, 32'h104, 32'h200, 0, 0, 1'b0, 2'b10);
      apply_stimulus(2'b11, 2'b00, 2'b00, 32'h104, 32'h204, 0, 0, 1'b0, 2'b01);
      apply_stimulus(2'b11, 2'b00, 2'b00, 32'h108, 32'h204, 0, 0, 1'b0, 2'b10);
      apply_stimulus(2'b11, 2'b00, 2'b00, 32'h108, 32'h208, 0, 0, 1'b0, 2'b01);

      // loader locked burst of 20 writes against a continuously requesting core
      k = 0;
      for (int i = 0; i < 22; i++) begin
         core_win = (i == 8) || (i == 17);
         apply_stimulus(2'b11, 2'b10, 2'b10, 32'h300, 32'h2000 + 32'(4 * k),
                        32'h0, 32'h5000 + 32'(k), 1'b0, core_win ? 2'b01 : 2'b10);
         if (!core_win) k++;
      end

      // core UART write stalled by a full FIFO while the loader reads
      for (int j = 0; j < 5; j++) begin
         apply_stimulus(2'b11, 2'b00, 2'b01, TX, 32'h400 + 32'(4 * j), 32'h41, 0, 1'b1, 2'b10);
      end
      apply_stimulus(2'b11, 2'b00, 2'b01, TX, 32'h414, 32'h41, 0, 1'b0, 2'b01);
      apply_stimulus(2'b10, 2'b00, 2'b00, 32'h0, 32'h414, 0, 0, 1'b0, 2'b10);

      // MMIO decode
      apply_stimulus(2'b01, 2'b00, 2'b00, STAT, 32'h0, 0, 0, 1'b1, 2'b01);
      apply_stimulus(2'b10, 2'b00, 2'b00, 32'h0, STAT, 0, 0, 1'b0, 2'b10);
      apply_stimulus(2'b01, 2'b00, 2'b00, TX, 32'h0, 0, 0, 1'b1, 2'b01);
      apply_stimulus(2'b01, 2'b00, 2'b01, STAT, 32'h0, 32'h77, 0, 1'b0, 2'b01);
      apply_stimulus(2'b01, 2'b00, 2'b01, TX, 32'h0, 32'h42, 0, 1'b1, 2'b00);
      apply_stimulus(2'b01, 2'b00, 2'b01, TX, 32'h0, 32'h42, 0, 1'b0, 2'b01);

      // reset right after a granted read drops the pending return
      apply_stimulus(2'b01, 2'b00, 2'b00, 32'h500, 32'h0, 0, 0, 1'b0, 2'b01);
      void'(rq.pop_back());
      @(posedge clk);
      #1;
      rst = 1'b0;
      req = 2'b11;
      #1;
      check_quiet("reset_mid");
      @(posedge clk);
      #1;
      req = 2'b00;
      rst = 1'b1;
      apply_stimulus(2'b11, 2'b00, 2'b00, 32'h600, 32'h700, 0, 0, 1'b0, 2'b01);
      apply_stimulus(2'b11, 2'b00, 2'b00, 32'h604, 32'h700, 0, 0, 1'b0, 2'b10);
      repeat (3) apply_stimulus(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 0, 0, 1'b0, 2'b00);

      @(negedge clk);
      #1;
      check_output("grants_left", gq.size(), 32'h0);
      check_output("reads_left", rq.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single dmem/MMIO data port between two requesters: the core (port 0) and a DMA/program loader (port 1).
- Round-robin arbitration with bounded bus locking.
- Decodes the UART MMIO window and applies UART FIFO backpressure.
- Tracks the one-cycle dmem read latency and routes read data back to the owning requester.
- Sits between core/loader and the dmem and uartTx instances in soc.

Parameters:
- MAX_LOCK, 8, max consecutive grants to one locking requester before a forced release.
- UART_TX_ADDR, 32'hFFFF_FFFC, UART transmit data register (write).
- UART_STAT_ADDR, 32'hFFFF_FFF8, UART status register (read; bit0 = fifoFull).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req  in  2  per-requester request; [0]=core, [1]=loader
- lock  in  2  per-requester lock hint, valid with req
- wen  in  2  1=write, 0=read
- addr0/addr1  in  32  byte address
- wdata0/wdata1  in  32  write data
- size0/size1  in  3  access size, passed through unchanged
- gnt  out  2  one-hot grant, combinational, same cycle as req
- rvalid  out  2  one-hot read-data valid, registered
- rdata  out  32  read data, qualified by rvalid
- mRen, mWen  out  1  dmem read/write enables
- mAddr, mWdata  out  32  dmem address/data
- mSize  out  3  dmem size
- mRdata  in  32  dmem read data, 1 cycle after mRen
- uartWen  out  1  uartTx write strobe
- uartData  out  8  = winner wdata[7:0]
- uartFifoFull  in  1  uartTx backpressure

Behaviour:
- Reset (rst low, async): gnt, rvalid, mRen, mWen, uartWen all 0; rdata=0; rr pointer=0 (core preferred); lock counter=0; owner reg cleared.
- Requester holds addr/wdata/size/wen/lock stable from req until gnt.
- Eligibility: a request is eligible unless it is a write to UART_TX_ADDR while uartFifoFull=1. Ineligible requests get no gnt and do not block the other port.
- Arbitration each cycle:
  - If locked owner L has eligible req, lock=1 and lockCnt<MAX_LOCK: grant L.
  - Else grant the eligible requester starting from rr pointer.
  - At most one gnt bit per cycle.
- After each grant: rr pointer = other port.
  - lockCnt increments when the winner equals the previous winner with lock=1; otherwise it resets to 1.
  - At lockCnt==MAX_LOCK, lock is ignored for one arbitration: the other port wins if eligible, else the owner continues and lockCnt restarts at 1.
- Decode of granted access:
  - addr==UART_TX_ADDR write: uartWen=1, no dmem enable.
  - addr==UART_TX_ADDR read: rdata=0.
  - addr==UART_STAT_ADDR read: rdata={31'b0, uartFifoFull}, sampled in grant cycle.
  - addr==UART_STAT_ADDR write: granted, ignored.
  - All other addresses go to dmem; mAddr/mWdata/mSize are muxed from the winner.
- Read latency: for a granted read, rvalid[winner]=1 exactly one cycle later, with rdata = mRdata (dmem) or the captured MMIO value.
  - Owner and source select are registered at grant.
  - Back-to-back grants are allowed: a read's rvalid and the next grant may occur in the same cycle, giving a throughput of 1 access/cycle.
- No grant in a cycle: mRen=mWen=uartWen=0; mAddr/mWdata hold the last winner's values (don't-care).
- Simultaneous events:
  - Both ports request with no lock: rr pointer decides.
  - UART full plus the other port requesting dmem: the other port is granted.
  - uartFifoFull falling: the blocked write is eligible in the same cycle.
- Reset mid-read: the pending rvalid is dropped; no rvalid after rst deasserts.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- When defined: two 32-bit wrapping grant counters (one per port) and a 32-bit contention counter (cycles with both req high, one denied).
  - Readable at 0xFFFF_FFF0 (core grants), 0xFFFF_FFF4 (loader grants), 0xFFFF_FFEC (contention), with standard 1-cycle rvalid.
  - Writes to these addresses clear the addressed counter.
  - Reset value 0.
- When undefined: these addresses decode as dmem; no counter logic.

Test Plan:
- Core read 0x100 while dmem returns 0xDEADBEEF -> gnt=01, mRen=1 in cycle N; rvalid=01, rdata=0xDEADBEEF in N+1.
- Both ports read continuously, no lock -> grants alternate 01,10,01,10; every rvalid matches the prior cycle's gnt.
- Loader req+lock writing 20 words while core requests, MAX_LOCK=8 -> loader gets 8 grants, core gets 1, loader gets 8 more, and so on.
- Core writes 0x41 to 0xFFFF_FFFC with uartFifoFull=1 for 5 cycles while loader reads -> no core gnt for 5 cycles, loader served each cycle; at release uartWen=1, uartData=0x41, mWen=0.
- Read 0xFFFF_FFF8 with uartFifoFull=1 -> rvalid next cycle, rdata=0x1, mRen=0.
- rst pulled low the cycle after a granted read -> no rvalid; all outputs 0 asynchronously; first grant after release goes to core when both request.
